// File: rtl/gyruss_sound_cmd_rx_if.sv
// Sound request bus between main board, sound CPU and command receiver.
// master drives strobes/pulses, slave returns command, IRQ and status.
interface gyruss_sound_cmd_rx_if;
  logic       SNDRQ;
  logic [7:0] SNDNO;
  logic       RD_CMD;
  logic       IACK;
  logic       OVR_CLR;
  logic [7:0] CMD;
  logic       IRQ;
  logic       PEND;
  logic       OVR;

  modport master (
    output SNDRQ, SNDNO, RD_CMD, IACK, OVR_CLR,
    input  CMD, IRQ, PEND, OVR
  );

  modport slave (
    input  SNDRQ, SNDNO, RD_CMD, IACK, OVR_CLR,
    output CMD, IRQ, PEND, OVR
  );
endinterface

// File: rtl/gyruss_sound_cmd_rx.sv
// Gyruss sound-board command receiver: SNDRQ sync, SNDNO capture, IRQ handshake.
// Define SOUND_CMD_FIFO_EN to queue commands in a 2**FIFO_AW entry FIFO.
module gyruss_sound_cmd_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_AW     = 2
) (
  input logic MCLK,
  input logic RESET,
  gyruss_sound_cmd_rx_if.slave bus
);

  if (SYNC_STAGES < 2 || FIFO_AW < 1) begin : g_bad_param
    $error("gyruss_sound_cmd_rx: SYNC_STAGES>=2, FIFO_AW>=1");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    SERVE = 2'd2
  } st_t;

  localparam int PRIME = SYNC_STAGES + 1;
  localparam int PW    = $clog2(PRIME + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   edge_q;
  logic                   req_q;
  logic [PW-1:0]          prime_q;
  logic                   sync_out;
  logic                   primed;

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign primed   = (prime_q == PW'(PRIME));

  // Edges are ignored until the edge reg has seen the settled sync output,
  // so a SNDRQ still high across reset release is not taken as a request.
  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      sync_q  <= '0;
      edge_q  <= 1'b0;
      req_q   <= 1'b0;
      prime_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.SNDRQ};
      edge_q <= sync_out;
      req_q  <= primed & sync_out & ~edge_q;
      if (!primed)
        prime_q <= prime_q + PW'(1);
    end
  end

`ifdef SOUND_CMD_FIFO_EN

  localparam int DEPTH = 1 << FIFO_AW;

  logic [7:0]       mem [DEPTH];
  logic [FIFO_AW-1:0] wp_q;
  logic [FIFO_AW-1:0] rp_q;
  logic [FIFO_AW:0] cnt_q;
  logic [FIFO_AW:0] cnt_n;
  logic [7:0]       last_q;
  st_t              st_q;
  st_t              st_n;
  logic             irq_q;
  logic             pend_q;
  logic             ovr_q;
  logic             empty;
  logic             full;
  logic             pop;
  logic             push;
  logic             drop;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == (FIFO_AW+1)'(DEPTH));
  assign pop   = bus.RD_CMD & ~empty;
  assign push  = req_q & (~full | pop);
  assign drop  = req_q & full & ~pop;

  always_comb begin
    cnt_n = cnt_q + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
    st_n  = st_q;
    if (pop)
      st_n = (cnt_n == '0) ? IDLE : ARMED;
    else if (bus.IACK && st_q == ARMED)
      st_n = SERVE;
    else if (cnt_n != '0 && st_q == IDLE)
      st_n = ARMED;
  end

  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= 8'h00;
      wp_q   <= '0;
      rp_q   <= '0;
      cnt_q  <= '0;
      last_q <= 8'h00;
      st_q   <= IDLE;
      irq_q  <= 1'b0;
      pend_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      if (push) begin
        mem[wp_q] <= bus.SNDNO;
        wp_q      <= wp_q + 1'b1;
      end
      if (pop) begin
        last_q <= mem[rp_q];
        rp_q   <= rp_q + 1'b1;
      end
      cnt_q  <= cnt_n;
      st_q   <= st_n;
      irq_q  <= (cnt_n != '0) && (st_n != SERVE);
      pend_q <= (cnt_n != '0);
      ovr_q  <= drop | (ovr_q & ~bus.OVR_CLR);
    end
  end

  // Once drained, keep presenting the last byte read.
  assign bus.CMD  = empty ? last_q : mem[rp_q];
  assign bus.IRQ  = irq_q;
  assign bus.PEND = pend_q;
  assign bus.OVR  = ovr_q;

`else

  logic [7:0] cmd_q;
  st_t        st_q;
  logic       irq_q;
  logic       pend_q;
  logic       ovr_q;

  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      cmd_q  <= 8'h00;
      st_q   <= IDLE;
      irq_q  <= 1'b0;
      pend_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      ovr_q <= (req_q & pend_q & ~bus.RD_CMD)
             | (ovr_q & ~bus.OVR_CLR);
      if (req_q) begin
        cmd_q  <= bus.SNDNO;
        st_q   <= ARMED;
        irq_q  <= 1'b1;
        pend_q <= 1'b1;
      end else begin
        case (st_q)
          ARMED: begin
            if (bus.RD_CMD) begin
              st_q   <= IDLE;
              irq_q  <= 1'b0;
              pend_q <= 1'b0;
            end else if (bus.IACK) begin
              st_q  <= SERVE;
              irq_q <= 1'b0;
            end
          end
          SERVE: begin
            if (bus.RD_CMD) begin
              st_q   <= IDLE;
              pend_q <= 1'b0;
            end
          end
          default: begin
            st_q   <= IDLE;
            irq_q  <= 1'b0;
            pend_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.CMD  = cmd_q;
  assign bus.IRQ  = irq_q;
  assign bus.PEND = pend_q;
  assign bus.OVR  = ovr_q;

`endif

endmodule

// File: doc/gyruss_sound_cmd_rx.md
Name: gyruss_sound_cmd_rx

Overview:
- Sound-board receiver for the main-CPU sound request interface (SNDRQ strobe, SNDNO command byte).
- Synchronises SNDRQ into the sound domain and captures SNDNO on the request edge.
- Raises an interrupt to the sound CPU and handshakes via interrupt acknowledge and command-port read.
- Sits between the main board outputs and the sound CPU address decoder/data selector.

Parameters:
SYNC_STAGES, 2, flip-flop stages on SNDRQ before edge detection (min 2)
FIFO_AW, 2, log2 command FIFO depth (used only with optional feature)

Ports:
MCLK  in  1  system clock
RESET  in  1  asynchronous, active-high reset
SNDRQ  in  1  request strobe from main CPU, asynchronous, high >=2 main-CPU cycles
SNDNO  in  8  command byte, stable from before SNDRQ rise until next write
RD_CMD  in  1  sound-CPU read of command port, one-MCLK pulse
IACK  in  1  sound-CPU interrupt acknowledge, one-MCLK pulse
OVR_CLR  in  1  clears overrun flag, one-MCLK pulse
CMD  out  8  current command byte (latch or FIFO head)
IRQ  out  1  interrupt request to sound CPU, registered
PEND  out  1  unread command present
OVR  out  1  sticky overrun flag

Behaviour:
- Reset (async): sync chain 0, edge reg 0, CMD=8'h00, IRQ=0, PEND=0, OVR=0, state IDLE.
- REQ = sync output high and previous sample low; exactly one-cycle pulse per SNDRQ rising edge. Level/hold time of SNDRQ otherwise ignored.
- Latency: SNDRQ first sampled high at edge n -> REQ at n+SYNC_STAGES -> CMD updated, IRQ=1, PEND=1 at n+SYNC_STAGES+1.
- CMD captures SNDNO on the REQ cycle.
- State machine (single-latch build):
  - IDLE: REQ -> ARMED.
  - ARMED: IRQ=1, PEND=1.
    - IACK -> SERVE.
    - RD_CMD (polled) -> IDLE.
  - SERVE: IRQ=0, PEND=1.
    - RD_CMD -> IDLE.
  - Any state, REQ while PEND=1 and no RD_CMD that cycle: overwrite CMD, OVR=1, -> ARMED.
- Simultaneous REQ and RD_CMD: read observes old CMD that cycle; new byte latched; -> ARMED; OVR unchanged.
- IACK outside ARMED: ignored. RD_CMD in IDLE: ignored; CMD holds last value.
- OVR_CLR clears OVR. OVR_CLR coincident with a new overrun: OVR stays 1 (set wins).
- PEND=1 in ARMED and SERVE, else 0.
- Reset mid-handshake: immediate return to reset values. A SNDRQ still high after reset release does not generate REQ, because the edge reg is loaded from the sync output on the first post-reset cycles.

Optional Feature:
SOUND_CMD_FIFO_EN
- Defined:
  - Captured bytes push into a 2^FIFO_AW entry FIFO; CMD shows the head; RD_CMD pops.
  - PEND = not empty.
  - IRQ=1 when not empty and state is not SERVE. IACK -> SERVE. RD_CMD pop -> IDLE if the FIFO becomes empty, else ARMED.
  - Push when full: byte dropped, OVR=1, contents unchanged.
  - Push and pop in the same cycle: both take effect, count unchanged, never an overrun.
  - Pointers wrap modulo depth.
- Undefined: single latch behaviour above; FIFO_AW unused.

Test Plan:
- Reset, SNDNO=8'h3C, SNDRQ pulse 32 MCLK -> IRQ=1 and CMD=8'h3C exactly SYNC_STAGES+1 MCLK after first high sample; PEND=1, OVR=0.
- From ARMED, IACK -> IRQ=0 next cycle, PEND=1; then RD_CMD -> PEND=0, CMD still 8'h3C.
- Polled path: request 8'h11, RD_CMD without IACK -> IRQ=0, PEND=0, state IDLE.
- Overrun: request 8'h21 then 8'h22 without reads -> CMD=8'h22, OVR=1; OVR_CLR -> OVR=0.
- REQ and RD_CMD in the same cycle (request 8'h40 pending, 8'h41 arrives) -> OVR=0, CMD=8'h41, IRQ=1.
- FIFO build, depth 4: push 8'h01..8'h05 -> OVR=1; pops return 01,02,03,04, then PEND=0 and IRQ=0.
